// File: rtl/cache_assoc_wb_if.sv
// rtl/cache_assoc_wb_if.sv - core request and main-memory beat signals for cache_assoc_wb
interface cache_assoc_wb_if;
   logic        Enable;
   logic        read_in;
   logic        write_in;
   logic [31:0] addr_in;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        cache_hit;
   logic        load;
   logic        store;
   logic [31:0] addr_out;
   logic [31:0] store_data;
   logic [31:0] load_data;
   logic        complete;

   modport slave (
      input  Enable, read_in, write_in, addr_in, write_data, load_data, complete,
      output read_data, cache_hit, load, store, addr_out, store_data
   );

   modport master (
      output Enable, read_in, write_in, addr_in, write_data, load_data, complete,
      input  read_data, cache_hit, load, store, addr_out, store_data
   );
endinterface

// File: rtl/cache_assoc_wb.sv
// rtl/cache_assoc_wb.sv - N-way set-associative write-back, write-allocate data cache
// Optional hit/miss counters are enabled by defining CACHE_STATS_EN.
module cache_assoc_wb #(
   parameter int WAYS       = 2,
   parameter int SETS       = 16,
   parameter int LINE_WORDS = 16
) (
   input  logic             clk,
   input  logic             rst,
   cache_assoc_wb_if.slave  bus
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count
`endif
);
   localparam int IDX_W = $clog2(SETS);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int TAG_W = 30 - IDX_W - OFF_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, RESP} state_t;

   state_t             state;
   logic [TAG_W-1:0]   req_tag;
   logic [IDX_W-1:0]   req_idx;
   logic [OFF_W-1:0]   req_off;
   logic               req_write;
   logic [31:0]        req_wdata;
   logic [WAY_W-1:0]   way_r;
   logic [OFF_W-1:0]   cnt;
   logic [WAY_W-1:0]   rr_ptr [SETS];
   logic [WAYS-1:0]    valid  [SETS];
   logic [WAYS-1:0]    dirty  [SETS];

   logic [TAG_W-1:0]   tag_mem  [WAYS][SETS];
   logic [31:0]        data_mem [WAYS][SETS][LINE_WORDS];

   logic               hit;
   logic [WAY_W-1:0]   hit_way;
   logic               inv_found;
   logic [WAY_W-1:0]   inv_way;
   logic [WAY_W-1:0]   victim;
   logic [WAY_W-1:0]   rr_next;
   logic               last_beat;
   logic [OFF_W-1:0]   cnt_inc;
   logic [31:0]        fill_word;
   logic               unused_addr_bits;

   assign unused_addr_bits = ^bus.addr_in[1:0];

   // Descending scan so the lowest-numbered invalid way wins.
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[req_idx][w] && tag_mem[w][req_idx] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid[req_idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
   end

   assign victim    = inv_found ? inv_way : rr_ptr[req_idx];
   assign rr_next   = (WAYS == 1) ? '0 : rr_ptr[req_idx] + 1'b1;
   assign last_beat = (cnt == OFF_W'(LINE_WORDS - 1));
   assign cnt_inc   = cnt + 1'b1;
   // The requested word may be the one arriving on the final refill beat.
   assign fill_word = (req_off == OFF_W'(LINE_WORDS - 1)) ? bus.load_data
                                                         : data_mem[way_r][req_idx][req_off];

   always_ff @(posedge clk) begin
      if (rst) begin
         if (state == REFILL && bus.complete) begin
            data_mem[way_r][req_idx][cnt] <= bus.load_data;
            if (last_beat) tag_mem[way_r][req_idx] <= req_tag;
         end else if (state == RESP && req_write) begin
            data_mem[way_r][req_idx][req_off] <= req_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         req_tag        <= '0;
         req_idx        <= '0;
         req_off        <= '0;
         req_write      <= 1'b0;
         req_wdata      <= '0;
         way_r          <= '0;
         cnt            <= '0;
         bus.read_data  <= '0;
         bus.cache_hit  <= 1'b0;
         bus.load       <= 1'b0;
         bus.store      <= 1'b0;
         bus.addr_out   <= '0;
         bus.store_data <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid[s]  <= '0;
            dirty[s]  <= '0;
            rr_ptr[s] <= '0;
         end
`ifdef CACHE_STATS_EN
         hit_count  <= '0;
         miss_count <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.Enable && (bus.read_in || bus.write_in)) begin
                  req_tag   <= bus.addr_in[31 -: TAG_W];
                  req_idx   <= bus.addr_in[OFF_W+2 +: IDX_W];
                  req_off   <= bus.addr_in[2 +: OFF_W];
                  req_write <= bus.write_in;
                  req_wdata <= bus.write_data;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: begin
`ifdef CACHE_STATS_EN
               if (hit) hit_count  <= hit_count + 1'b1;
               else     miss_count <= miss_count + 1'b1;
`endif
               if (hit) begin
                  way_r <= hit_way;
                  if (!req_write) bus.read_data <= data_mem[hit_way][req_idx][req_off];
                  bus.cache_hit <= 1'b1;
                  state         <= RESP;
               end else begin
                  way_r <= victim;
                  cnt   <= '0;
                  if (valid[req_idx][victim] && dirty[req_idx][victim]) begin
                     bus.store      <= 1'b1;
                     bus.addr_out   <= {tag_mem[victim][req_idx], req_idx, {OFF_W{1'b0}}, 2'b00};
                     bus.store_data <= data_mem[victim][req_idx][0];
                     state          <= WB;
                  end else begin
                     bus.load     <= 1'b1;
                     bus.addr_out <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                     state        <= REFILL;
                  end
               end
            end
            WB: begin
               if (bus.complete) begin
                  if (last_beat) begin
                     cnt            <= '0;
                     bus.store      <= 1'b0;
                     bus.store_data <= '0;
                     bus.load       <= 1'b1;
                     bus.addr_out   <= {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
                     state          <= REFILL;
                  end else begin
                     cnt            <= cnt_inc;
                     bus.addr_out   <= {tag_mem[way_r][req_idx], req_idx, cnt_inc, 2'b00};
                     bus.store_data <= data_mem[way_r][req_idx][cnt_inc];
                  end
               end
            end
            REFILL: begin
               if (bus.complete) begin
                  if (last_beat) begin
                     cnt                   <= '0;
                     bus.load              <= 1'b0;
                     valid[req_idx][way_r] <= 1'b1;
                     dirty[req_idx][way_r] <= 1'b0;
                     rr_ptr[req_idx]       <= rr_next;
                     if (!req_write) bus.read_data <= fill_word;
                     bus.cache_hit         <= 1'b1;
                     state                 <= RESP;
                  end else begin
                     cnt          <= cnt_inc;
                     bus.addr_out <= {req_tag, req_idx, cnt_inc, 2'b00};
                  end
               end
            end
            RESP: begin
               bus.cache_hit <= 1'b0;
               if (req_write) dirty[req_idx][way_r] <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
